// File: rtl/cnn_window_if.sv
// cnn_window_if: pixel-in / window-out handshake bundle for cnn_window_gen.
interface cnn_window_if #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8,
    parameter int K     = 2
);
    logic                       in_valid;
    logic                       in_ready;
    logic [PIX_W-1:0]           in_pix;
    logic                       out_valid;
    logic                       out_ready;
    logic [K*K*PIX_W-1:0]       out_win;
    logic [$clog2(IMG_H)-1:0]   out_row;
    logic [$clog2(IMG_W)-1:0]   out_col;
    logic                       frame_done;
    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_win, out_row, out_col, frame_done
    );
    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_win, out_row, out_col, frame_done
    );
endinterface

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: KxK sliding-window generator over a raster-order pixel stream,
// with K-1 circular line buffers, a window shift register and one output register.
module cnn_window_gen #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256,
    parameter int PIX_W = 8,
    parameter int K     = 2
) (
    input logic       clk,
    input logic       rst,
    cnn_window_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int PW = $clog2(K);
    localparam int WW = K * PIX_W;
    typedef enum logic {S_FILL, S_STREAM} state_t;
    state_t                 state;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [PW-1:0]          wp;
    logic [(K-1)*PIX_W-1:0] lb [IMG_W];
    logic [(K-1)*PIX_W-1:0] rd, wr;
    logic [PIX_W-1:0]       col_pix [K];
    logic [(K-1)*PIX_W-1:0] w [K];
    logic [WW-1:0]          nxt [K];
    logic [K*WW-1:0]        win;
    logic                   acc, emit, eol, eof;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign acc  = bus.in_valid && bus.in_ready;
    assign eol  = col == CW'(IMG_W - 1);
    assign eof  = eol && row == RW'(IMG_H - 1);
    assign emit = state == S_STREAM && col >= CW'(K - 1);
    assign rd   = lb[col];
    // wp names the slot holding the oldest buffered row; tap r sits r slots after it
    always_comb begin
        wr = rd;
        wr[int'(wp)*PIX_W +: PIX_W] = bus.in_pix;
        win = '0;
        for (int r = 0; r < K; r++) begin
            col_pix[r] = (r == K - 1) ? bus.in_pix
                       : rd[(int'(wp) + r - ((int'(wp) + r >= K - 1) ? K - 1 : 0))*PIX_W +: PIX_W];
            nxt[r] = {col_pix[r], w[r]};
            win[r*WW +: WW] = nxt[r];
        end
    end
    always_ff @(posedge clk)
        if (acc) begin
            lb[col] <= wr;
            for (int r = 0; r < K; r++) w[r] <= nxt[r][WW-1:PIX_W];
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state          <= S_FILL;
            row            <= '0;
            col            <= '0;
            wp             <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_win    <= '0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= bus.out_valid && bus.out_ready &&
                              bus.out_row == RW'(IMG_H - K) && bus.out_col == CW'(IMG_W - K);
            if (acc) begin
                col <= eol ? '0 : col + 1'b1;
                if (eol) begin
                    row <= eof ? '0 : row + 1'b1;
                    wp  <= (wp == PW'(K - 2)) ? '0 : wp + 1'b1;
                end
                if (state == S_FILL && eol && row == RW'(K - 2))
                    state <= S_STREAM;
                else if (state == S_STREAM && eof)
                    state <= S_FILL;
            end
            if (acc && emit) begin
                bus.out_valid <= 1'b1;
                bus.out_win   <= win;
                bus.out_row   <= row - RW'(K - 1);
                bus.out_col   <= col - CW'(K - 1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: directed + randomized checks of cnn_window_gen against a
// window list computed directly from the frame's pixel array.
module tb_cnn_window_gen;
    localparam int W2 = 4, H2 = 3, K2 = 2;
    localparam int W3 = 5, H3 = 5, K3 = 3;
    localparam int P  = 8;

    typedef struct {
        logic [71:0] win;
        int          row;
        int          col;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    int         n_assert = 0;
    int         n_fail = 0;
    int         fds;
    logic [7:0] px[$];
    exp_t       exp_q[$];

    cnn_window_if #(.IMG_W(W2), .IMG_H(H2), .PIX_W(P), .K(K2)) b2 ();
    cnn_window_if #(.IMG_W(W3), .IMG_H(H3), .PIX_W(P), .K(K3)) b3 ();

    cnn_window_gen #(.IMG_W(W2), .IMG_H(H2), .PIX_W(P), .K(K2)) u2 (.clk(clk), .rst(rst), .bus(b2));
    cnn_window_gen #(.IMG_W(W3), .IMG_H(H3), .PIX_W(P), .K(K3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // every KxK window of each frame in px, in raster order of its top-left corner
    task automatic build(input int k, input int w, input int h, input int frames);
        exp_t e;
        for (int f = 0; f < frames; f++)
            for (int y = 0; y <= h - k; y++)
                for (int x = 0; x <= w - k; x++) begin
                    e.win = '0;
                    for (int r = 0; r < k; r++)
                        for (int c = 0; c < k; c++)
                            e.win[(r*k + c)*8 +: 8] = px[f*w*h + (y + r)*w + x + c];
                    e.row = y;
                    e.col = x;
                    exp_q.push_back(e);
                end
    endtask

    task automatic fill_seq(input int base, input int n);
        for (int i = 0; i < n; i++) px.push_back(8'(base + i));
    endtask

    task automatic stream2(input int max_px, input int gap_pct, input int ready_pct,
                           input int stall_at, input int stall_len, output int fd);
        int   sent = 0, cyc = 0, stalled = 0, nwin = 0;
        bit   prev_final = 1'b0, stall;
        exp_t e;
        fd = 0;
        while (cyc < 3000 && (sent < max_px ||
               (max_px == px.size() && (exp_q.size() > 0 || b2.out_valid || prev_final)))) begin
            cyc++;
            b2.in_valid  = sent < max_px && $urandom_range(99) >= gap_pct;
            b2.in_pix    = (sent < px.size()) ? px[sent] : 8'h00;
            stall        = nwin == stall_at && stalled < stall_len && b2.out_valid;
            stalled     += int'(stall);
            b2.out_ready = !stall && $urandom_range(99) < ready_pct;
            @(negedge clk);
            chk("in_ready", b2.in_ready, !b2.out_valid || b2.out_ready);
            chk("frame_done", b2.frame_done, prev_final);
            if (b2.frame_done) fd++;
            prev_final = 1'b0;
            if (exp_q.size() == 0) chk("no_extra_window", b2.out_valid, 1'b0);
            else if (b2.out_valid) begin
                e = exp_q[0];
                chk("win", b2.out_win, e.win);
                chk("row", b2.out_row, e.row);
                chk("col", b2.out_col, e.col);
                if (b2.out_ready) begin
                    void'(exp_q.pop_front());
                    nwin++;
                    prev_final = e.row == H2 - K2 && e.col == W2 - K2;
                end
            end
            if (b2.in_valid && b2.in_ready) sent++;
            @(posedge clk);
            #1;
        end
        b2.in_valid = 1'b0;
        chk("stream_done", sent == max_px && (max_px < px.size() || exp_q.size() == 0), 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        b2.in_valid = 1'b0; b2.in_pix = '0; b2.out_ready = 1'b1;
        b3.in_valid = 1'b0; b3.in_pix = '0; b3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", b2.out_valid, 1'b0);
        chk("rst_out_win", b2.out_win, '0);
        chk("rst_out_row", b2.out_row, '0);
        chk("rst_out_col", b2.out_col, '0);
        chk("rst_frame_done", b2.frame_done, 1'b0);
        chk("rst_in_ready", b2.in_ready, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        px.delete(); fill_seq(0, 12); build(K2, W2, H2, 1);
        stream2(12, 0, 100, -1, 0, fds);
        chk("basic_frame_done_count", fds, 1);

        build(K2, W2, H2, 1);
        stream2(12, 0, 100, 1, 5, fds);
        chk("bp_frame_done_count", fds, 1);

        build(K2, W2, H2, 1);
        stream2(12, 40, 100, -1, 0, fds);
        chk("gap_frame_done_count", fds, 1);

        px.delete(); fill_seq(0, 12); fill_seq(100, 12); build(K2, W2, H2, 2);
        stream2(24, 0, 100, -1, 0, fds);
        chk("b2b_frame_done_count", fds, 2);

        px.delete();
        for (int i = 0; i < 3*W2*H2; i++) px.push_back(8'($urandom));
        build(K2, W2, H2, 3);
        stream2(3*W2*H2, 30, 60, -1, 0, fds);
        chk("rand_frame_done_count", fds, 3);

        px.delete(); fill_seq(0, 12); build(K2, W2, H2, 1);
        stream2(7, 0, 100, -1, 0, fds);
        exp_q.delete();
        chk("pre_rst_out_valid", b2.out_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", b2.out_valid, 1'b0);
        chk("async_rst_in_ready", b2.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        build(K2, W2, H2, 1);
        stream2(12, 0, 100, -1, 0, fds);
        chk("post_rst_frame_done_count", fds, 1);

        px.delete(); fill_seq(0, W3*H3); build(K3, W3, H3, 1);
        for (int i = 0; i < W3*H3 + 5; i++) begin
            b3.in_valid = i < W3*H3;
            b3.in_pix   = 8'(i);
            @(negedge clk);
            if (b3.out_valid && exp_q.size() > 0) begin
                chk("k3_win", b3.out_win, exp_q[0].win);
                chk("k3_row", b3.out_row, exp_q[0].row);
                chk("k3_col", b3.out_col, exp_q[0].col);
                void'(exp_q.pop_front());
            end
            @(posedge clk);
            #1;
        end
        b3.in_valid = 1'b0;
        chk("k3_window_count", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
